// File: rtl/gpio_bridge_pkg.sv
// Shared types and helpers for the CPU-to-gpio_ip MMIO bridge: FSM states,
// window offsets, STATUS bit positions and the request descriptor.
package gpio_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ_REQ,
      READ_WAIT,
      STAT_RD
   } state_t;

   localparam logic [2:0] OFF_DATA   = 3'h0;
   localparam logic [2:0] OFF_STATUS = 3'h4;

   localparam int STAT_MISS_BIT = 16;
   localparam int STAT_OVF_BIT  = 17;

   typedef struct packed {
      logic        is_load;
      logic [2:0]  off;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } req_t;

   localparam int REQ_W = $bits(req_t);

   function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
      logic [31:0] merged;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/gpio_bridge_pending_slot.sv
// One-deep holding register for requests that arrive while the bridge is busy.
// Flags overflow whenever an offered request finds no room.
module gpio_bridge_pending_slot
   import gpio_bridge_pkg::*;
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             first_valid,
   input  logic [REQ_W-1:0] first_req,
   input  logic             second_valid,
   input  logic [REQ_W-1:0] second_req,
   input  logic             bypass,
   input  logic             pop,
   output logic             full,
   output logic [REQ_W-1:0] slot_req,
   output logic             overflow
);

   logic             full_reg;
   logic [REQ_W-1:0] slot_reg;
   logic             cand_valid;
   logic             extra_valid;
   logic [REQ_W-1:0] cand_req;

   // When the FSM takes the first request directly, only the second competes for the slot.
   always_comb begin
      cand_valid  = bypass ? second_valid : first_valid;
      cand_req    = bypass ? second_req : first_req;
      extra_valid = !bypass && second_valid;
      overflow    = full_reg ? (cand_valid || extra_valid) : extra_valid;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         full_reg <= 1'b0;
         slot_reg <= '0;
      end else if (full_reg) begin
         if (pop) begin
            full_reg <= 1'b0;
         end
      end else if (cand_valid) begin
         full_reg <= 1'b1;
         slot_reg <= cand_req;
      end
   end

   assign full     = full_reg;
   assign slot_req = slot_reg;

endmodule

// File: rtl/gpio_mmio_bridge.sv
// MMIO bridge from the CPU data bus to gpio_ip: decodes an 8-byte window,
// byte-merges stores into a shadow word, and exposes a STATUS word.
module gpio_mmio_bridge
   import gpio_bridge_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0040_0000,
   parameter int          READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wmask,
   input  logic        mem_rstrb,
   output logic [31:0] mem_rdata,
   output logic        mem_rbusy,
   output logic        mem_wbusy,
   output logic        gpio_wr_en,
   output logic        gpio_rd_en,
   output logic [31:0] gpio_wdata,
   input  logic [31:0] gpio_rdata
);

   localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

   state_t      state_reg, state_next;
   logic [2:0]  lat_reg, lat_next;
   logic [31:0] rdata_reg, rdata_next;
   logic [31:0] gwdata_reg, gwdata_next;
   logic        rbusy_reg, rbusy_next;
   logic        wbusy_reg, wbusy_next;
   logic        wr_en_reg, wr_en_next;
   logic        rd_en_reg, rd_en_next;
   logic [31:0] shadow_reg;
   logic [15:0] wr_count_reg;
   logic        miss_err_reg;
   logic        ovf_reg;

   logic        hit, addr_misaligned, st_misaligned, ld_misaligned, st_ok, ld_ok;
   logic [2:0]  off;
   req_t        st_req, ld_req, first_req, issue_req, slot_req;
   logic [REQ_W-1:0] slot_bits;
   logic        first_valid, second_valid, slot_full, slot_ovf;
   logic        finishing, issue_slot, bypass, issue;
   logic        data_store, clr_miss, clr_ovf;
   logic [31:0] merged, status_word;

   // Stores are ordered ahead of loads when both arrive in the same cycle.
   always_comb begin
      hit             = mem_addr[31:3] == BASE_ADDR[31:3];
      addr_misaligned = mem_addr[1:0] != 2'b00;
      off             = {mem_addr[2], 2'b00};
      st_misaligned   = hit && (mem_wmask == 4'hF) && addr_misaligned;
      ld_misaligned   = hit && mem_rstrb && addr_misaligned;
      st_ok           = hit && (mem_wmask != 4'h0) && !st_misaligned;
      ld_ok           = hit && mem_rstrb && !addr_misaligned;
      st_req          = '{is_load: 1'b0, off: off, wdata: mem_wdata, wmask: mem_wmask};
      ld_req          = '{is_load: 1'b1, off: off, wdata: 32'h0, wmask: 4'h0};
      first_valid     = st_ok || ld_ok;
      first_req       = st_ok ? st_req : ld_req;
      second_valid    = st_ok && ld_ok;
   end

   gpio_bridge_pending_slot u_slot (
      .clk          (clk),
      .resetn       (resetn),
      .first_valid  (first_valid),
      .first_req    (first_req),
      .second_valid (second_valid),
      .second_req   (ld_req),
      .bypass       (bypass),
      .pop          (issue_slot),
      .full         (slot_full),
      .slot_req     (slot_bits),
      .overflow     (slot_ovf)
   );

   assign slot_req = req_t'(slot_bits);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg  <= IDLE;
         lat_reg    <= 3'd0;
         rdata_reg  <= 32'h0;
         gwdata_reg <= 32'h0;
         rbusy_reg  <= 1'b0;
         wbusy_reg  <= 1'b0;
         wr_en_reg  <= 1'b0;
         rd_en_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         lat_reg    <= lat_next;
         rdata_reg  <= rdata_next;
         gwdata_reg <= gwdata_next;
         rbusy_reg  <= rbusy_next;
         wbusy_reg  <= wbusy_next;
         wr_en_reg  <= wr_en_next;
         rd_en_reg  <= rd_en_next;
      end
   end

   // A held request launches on the closing edge of the current access, so no idle bubble.
   always_comb begin
      finishing   = (state_reg == WRITE) || (state_reg == STAT_RD) ||
                    ((state_reg == READ_WAIT) && (lat_reg == LAT_LAST));
      issue_slot  = slot_full && ((state_reg == IDLE) || finishing);
      bypass      = !slot_full && (state_reg == IDLE) && first_valid;
      issue       = issue_slot || bypass;
      issue_req   = issue_slot ? slot_req : first_req;
      merged      = byte_merge(shadow_reg, issue_req.wdata, issue_req.wmask);
      status_word = {14'h0, ovf_reg, miss_err_reg, wr_count_reg};

      state_next  = state_reg;
      lat_next    = lat_reg;
      rdata_next  = rdata_reg;
      gwdata_next = gwdata_reg;
      rbusy_next  = 1'b0;
      wbusy_next  = 1'b0;
      wr_en_next  = 1'b0;
      rd_en_next  = 1'b0;

      case (state_reg)
         READ_REQ: begin
            state_next = READ_WAIT;
            lat_next   = 3'd0;
            rbusy_next = 1'b1;
         end
         READ_WAIT: begin
            if (lat_reg == LAT_LAST) begin
               state_next = IDLE;
               rdata_next = gpio_rdata;
            end else begin
               lat_next   = lat_reg + 3'd1;
               rbusy_next = 1'b1;
            end
         end
         STAT_RD: begin
            state_next = IDLE;
            rdata_next = status_word;
         end
         WRITE:   state_next = IDLE;
         default: state_next = state_reg;
      endcase

      if (issue) begin
         if (issue_req.is_load) begin
            rbusy_next = 1'b1;
            if (issue_req.off == OFF_STATUS) begin
               state_next = STAT_RD;
            end else begin
               state_next = READ_REQ;
               rd_en_next = 1'b1;
            end
         end else begin
            state_next = WRITE;
            wbusy_next = 1'b1;
            if (issue_req.off == OFF_DATA) begin
               wr_en_next  = 1'b1;
               gwdata_next = merged;
            end
         end
      end
   end

   always_comb begin
      data_store = issue && !issue_req.is_load && (issue_req.off == OFF_DATA);
      clr_miss   = issue && !issue_req.is_load && (issue_req.off == OFF_STATUS) &&
                   issue_req.wdata[STAT_MISS_BIT];
      clr_ovf    = issue && !issue_req.is_load && (issue_req.off == OFF_STATUS) &&
                   issue_req.wdata[STAT_OVF_BIT];
   end

   // New error events win over a same-cycle write-1-to-clear.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         shadow_reg   <= 32'h0;
         wr_count_reg <= 16'h0;
         miss_err_reg <= 1'b0;
         ovf_reg      <= 1'b0;
      end else begin
         if (data_store) begin
            shadow_reg   <= merged;
            wr_count_reg <= wr_count_reg + 16'd1;
         end
         miss_err_reg <= (miss_err_reg && !clr_miss) || st_misaligned || ld_misaligned;
         ovf_reg      <= (ovf_reg && !clr_ovf) || slot_ovf;
      end
   end

   assign mem_rdata  = rdata_reg;
   assign mem_rbusy  = rbusy_reg;
   assign mem_wbusy  = wbusy_reg;
   assign gpio_wr_en = wr_en_reg;
   assign gpio_rd_en = rd_en_reg;
   assign gpio_wdata = gwdata_reg;

endmodule

// File: tb/tb_gpio_mmio_bridge.sv
// Scoreboard bench for gpio_mmio_bridge: directed scenarios plus random traffic
// checked against a transaction-level model of the window, shadow word and STATUS.
module tb_gpio_mmio_bridge;

   localparam logic [31:0] BASE = 32'h0040_0000;
   localparam int          LAT  = 1;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wmask = '0;
   logic        mem_rstrb = 1'b0;
   logic [31:0] mem_rdata;
   logic        mem_rbusy;
   logic        mem_wbusy;
   logic        gpio_wr_en;
   logic        gpio_rd_en;
   logic [31:0] gpio_wdata;
   logic [31:0] gpio_rdata;

   always #5 clk = ~clk;

   gpio_mmio_bridge #(.BASE_ADDR(BASE), .READ_LATENCY(LAT)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wmask  (mem_wmask),
      .mem_rstrb  (mem_rstrb),
      .mem_rdata  (mem_rdata),
      .mem_rbusy  (mem_rbusy),
      .mem_wbusy  (mem_wbusy),
      .gpio_wr_en (gpio_wr_en),
      .gpio_rd_en (gpio_rd_en),
      .gpio_wdata (gpio_wdata),
      .gpio_rdata (gpio_rdata)
   );

   // gpio_ip stand-in: data is valid only exactly LAT cycles after the read strobe.
   logic [31:0] gpio_reg;
   logic [7:0]  rd_pipe;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         gpio_reg <= 32'h0;
         rd_pipe  <= 8'h0;
      end else begin
         if (gpio_wr_en) gpio_reg <= gpio_wdata;
         rd_pipe <= {rd_pipe[6:0], gpio_rd_en};
      end
   end
   assign gpio_rdata = rd_pipe[LAT-1] ? gpio_reg : 32'hDEAD_BEEF;

   typedef struct {
      logic [31:0] data;
      int          width;
      bit          is_data;
   } rd_exp_t;

   logic [31:0] wr_q[$];
   rd_exp_t     rd_q[$];
   int          checks = 0;
   int          failures = 0;
   int          exp_wbusy = 0;
   int          act_wbusy = 0;
   int          cyc = 0;
   int          last_wr_cyc = -100;
   int          last_rd_cyc = -100;

   logic [31:0] m_shadow = 32'h0;
   logic [15:0] m_count = 16'h0;
   logic        m_miss = 1'b0;
   logic        m_ovf = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] status_val();
      return {14'h0, m_ovf, m_miss, m_count};
   endfunction

   task automatic model_reset();
      m_shadow = 32'h0;
      m_count  = 16'h0;
      m_miss   = 1'b0;
      m_ovf    = 1'b0;
   endtask

   task automatic model_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
      logic [31:0] bm;
      if (addr[31:3] != BASE[31:3] || mask == 4'h0) return;
      if (mask == 4'hF && addr[1:0] != 2'b00) begin
         m_miss = 1'b1;
         return;
      end
      exp_wbusy++;
      if (addr[2] == 1'b0) begin
         bm = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
         m_shadow = (m_shadow & ~bm) | (data & bm);
         m_count++;
         wr_q.push_back(m_shadow);
      end else begin
         if (data[17]) m_ovf = 1'b0;
         if (data[16]) m_miss = 1'b0;
      end
   endtask

   task automatic model_load(input logic [31:0] addr);
      rd_exp_t e;
      if (addr[31:3] != BASE[31:3]) return;
      if (addr[1:0] != 2'b00) begin
         m_miss = 1'b1;
         return;
      end
      if (addr[2] == 1'b0) begin
         e.data = m_shadow; e.width = 1 + LAT; e.is_data = 1'b1;
      end else begin
         e.data = status_val(); e.width = 1; e.is_data = 1'b0;
      end
      rd_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      mem_wmask = 4'h0;
      mem_rstrb = 1'b0;
   endtask

   task automatic wait_idle();
      int quiet = 0;
      for (int n = 0; n < 200 && quiet < 2; n++) begin
         tick();
         if (!mem_wbusy && !mem_rbusy) quiet++;
         else quiet = 0;
      end
      if (quiet < 2) begin
         checks++;
         failures++;
         $display("FAIL wait_idle: busy still high after 200 cycles (wbusy=%b rbusy=%b)", mem_wbusy, mem_rbusy);
      end
   endtask

   task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
      model_store(addr, data, mask);
      mem_addr = addr; mem_wdata = data; mem_wmask = mask;
      tick();
      idle_inputs();
      wait_idle();
      $display("store addr=%h data=%h mask=%h", addr, data, mask);
   endtask

   task automatic do_load(input logic [31:0] addr);
      model_load(addr);
      mem_addr = addr; mem_rstrb = 1'b1;
      tick();
      idle_inputs();
      wait_idle();
      $display("load  addr=%h rdata=%h", addr, mem_rdata);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      int r;
      r = $urandom_range(0, 9);
      a = BASE | (32'($urandom_range(0, 1)) << 2);
      if (r == 0) a = a + 32'd8;
      else if (r == 1) a = $urandom;
      else if (r == 2) a[1:0] = 2'($urandom_range(1, 3));
      return a;
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents a write strobe or completes a load.
   initial begin
      logic prev_wr, prev_rd, prev_rb, prev_wb;
      int rb_len;
      bit rd_seen;
      rd_exp_t e;
      prev_wr = 0; prev_rd = 0; prev_rb = 0; prev_wb = 0; rb_len = 0; rd_seen = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!resetn) begin
            prev_wr = 0; prev_rd = 0; prev_rb = 0; prev_wb = 0; rb_len = 0; rd_seen = 0;
         end else begin
            if (gpio_wr_en) begin
               last_wr_cyc = cyc;
               check("wr_en_prev_cycle", 32'(prev_wr), 32'h0);
               check("wr_en_with_wbusy", 32'(mem_wbusy), 32'h1);
               if (wr_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_write: gpio_wdata=%h with no write expected", gpio_wdata);
               end else begin
                  check("gpio_wdata", gpio_wdata, wr_q.pop_front());
               end
            end
            if (gpio_rd_en) begin
               last_rd_cyc = cyc;
               check("rd_en_prev_cycle", 32'(prev_rd), 32'h0);
               rd_seen = 1;
            end
            if (mem_rbusy) rb_len++;
            if (prev_rb && !mem_rbusy) begin
               if (rd_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_load: mem_rdata=%h with no load expected", mem_rdata);
               end else begin
                  e = rd_q.pop_front();
                  check("mem_rdata", mem_rdata, e.data);
                  check("rbusy_width", 32'(rb_len), 32'(e.width));
                  check("rd_en_issued", 32'(rd_seen), 32'(e.is_data));
               end
               rb_len = 0;
               rd_seen = 0;
            end
            if (prev_wb && !mem_wbusy) act_wbusy++;
            prev_wr = gpio_wr_en;
            prev_rd = gpio_rd_en;
            prev_rb = mem_rbusy;
            prev_wb = mem_wbusy;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a, d;
      logic [3:0]  m;
      idle_inputs();
      resetn = 1'b0;
      repeat (3) tick();
      check("rst_mem_rdata", mem_rdata, 32'h0);
      check("rst_mem_rbusy", 32'(mem_rbusy), 32'h0);
      check("rst_mem_wbusy", 32'(mem_wbusy), 32'h0);
      check("rst_gpio_wr_en", 32'(gpio_wr_en), 32'h0);
      check("rst_gpio_rd_en", 32'(gpio_rd_en), 32'h0);
      check("rst_gpio_wdata", gpio_wdata, 32'h0);
      resetn = 1'b1;
      tick();

      do_store(BASE, 32'h0000_0005, 4'hF);
      do_store(BASE, 32'hAABB_CCDD, 4'b0010);
      do_load(BASE + 32'd4);
      do_load(BASE);

      // Same-cycle store and load: the load must see the freshly written word.
      model_store(BASE, 32'h0000_000A, 4'hF);
      model_load(BASE);
      mem_addr = BASE; mem_wdata = 32'h0000_000A; mem_wmask = 4'hF; mem_rstrb = 1'b1;
      tick();
      idle_inputs();
      wait_idle();
      check("rd_follows_wr", 32'(last_rd_cyc - last_wr_cyc), 32'd1);
      $display("store+load addr=%h rdata=%h", BASE, mem_rdata);

      do_store(BASE + 32'd8, 32'h1234_5678, 4'hF);
      do_load(BASE + 32'd12);

      // Three back-to-back stores: the third finds the slot full and is dropped.
      for (int i = 0; i < 3; i++) begin
         d = 32'h11 * (i + 1);
         if (i < 2) model_store(BASE, d, 4'hF);
         else m_ovf = 1'b1;
         mem_addr = BASE; mem_wdata = d; mem_wmask = 4'hF;
         tick();
      end
      idle_inputs();
      wait_idle();
      $display("burst of 3 stores issued");
      do_load(BASE + 32'd4);
      do_store(BASE + 32'd4, 32'h0002_0000, 4'hF);
      do_load(BASE + 32'd4);

      do_store(BASE + 32'd1, 32'hFFFF_FFFF, 4'hF);
      do_load(BASE + 32'd4);
      do_store(BASE + 32'd4, 32'h0001_0000, 4'hF);
      do_load(BASE + 32'd2);
      do_load(BASE + 32'd4);

      for (int i = 0; i < 60; i++) begin
         a = rand_addr();
         if ($urandom_range(0, 9) < 6) begin
            d = $urandom;
            m = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(1, 15));
            do_store(a, d, m);
         end else begin
            do_load(a);
         end
      end
      do_load(BASE + 32'd4);

      // Asynchronous reset while a load sits in READ_WAIT.
      do_store(BASE, 32'h1234_5678, 4'hF);
      do_load(BASE);
      mem_addr = BASE; mem_rstrb = 1'b1;
      tick();
      idle_inputs();
      tick();
      check("rbusy_in_read_wait", 32'(mem_rbusy), 32'h1);
      #2;
      resetn = 1'b0;
      #1;
      check("async_rst_rbusy", 32'(mem_rbusy), 32'h0);
      check("async_rst_rd_en", 32'(gpio_rd_en), 32'h0);
      check("async_rst_rdata", mem_rdata, 32'h0);
      $display("reset asserted during read wait");
      model_reset();
      repeat (2) tick();
      resetn = 1'b1;
      tick();
      do_store(BASE, 32'h0000_0077, 4'hF);
      do_load(BASE);
      do_load(BASE + 32'd4);

      repeat (3) tick();
      check("wbusy_pulses", 32'(act_wbusy), 32'(exp_wbusy));
      check("writes_outstanding", 32'(wr_q.size()), 32'h0);
      check("loads_outstanding", 32'(rd_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
